// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async FIFO write port among
// N_REQ write-domain requesters; stalls on the FIFO's registered full flag.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int D_WIDTH   = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                       wclk,
   input  logic                       wrstn,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*D_WIDTH-1:0]   wdata_in,
   input  logic                       full,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           ack,
   output logic                       wen,
   output logic [D_WIDTH-1:0]         wdata,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy
);

   localparam int OW = $clog2(N_REQ);
   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
   logic [OW-1:0]     rr_ptr_q, rr_ptr_d;

   logic              found;
   logic [OW-1:0]     pick;
   logic [OW-1:0]     owner_inc;
   logic              ack_own;
   logic              last_beat;

   // Upward scan from rr_ptr with wrap; works for non-power-of-2 N_REQ.
   always_comb begin : pick_scan
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = OW'(idx);
         end
      end
   end

   assign ack       = gnt_q & req & {N_REQ{~full}};
   assign wen       = |ack;
   assign gnt       = gnt_q;
   assign owner     = owner_q;
   assign busy      = (state_q == GRANT);
   assign wdata     = busy ? wdata_in[owner_q*D_WIDTH +: D_WIDTH] : '0;
   assign ack_own   = ack[owner_q];
   assign last_beat = (beat_cnt_q == BW'(BURST_MAX - 1));
   assign owner_inc = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               state_d    = GRANT;
               gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
               owner_d    = pick;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (ack_own) beat_cnt_d = beat_cnt_q + 1'b1;
            // Release forces the single bubble cycle before the next arbitration.
            if ((ack_own && last_beat) || !req[owner_q]) begin
               state_d    = IDLE;
               gnt_d      = '0;
               beat_cnt_d = '0;
               rr_ptr_d   = owner_inc;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wclk or negedge wrstn) begin
      if (!wrstn) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

endmodule
